// File: rtl/rv32m_muldiv_if.sv
// Handshake/operand bundle between the execute-stage issue logic and the RV32M mul/div unit.
// The master modport issues requests and sinks results; the slave modport is the unit itself.
interface rv32m_muldiv_if;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_addr_i;
  logic        ready_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, rd_addr_i, ready_i,
    input  busy_o, valid_o, result_o, rd_addr_o
  );

  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, rd_addr_i, ready_i,
    output busy_o, valid_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fix-up stage.
// Optional macro RV32M_FAST_MUL_EN turns multiplies into a single-cycle product taken at accept.
module rv32m_muldiv #(
  parameter int XLEN = 32
) (
  input logic           clk_i,
  input logic           reset_i,
  rv32m_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;

  state_e      state_q;
  logic [2:0]  fn_q;
  logic [4:0]  rd_q;
  logic [31:0] b_q;
  logic [63:0] prod_q;
  logic        neg_q;
  logic        neg_rem_q;
  logic        bypass_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] result_q;

  logic        sgn_a, sgn_b, neg_a, neg_b, div0, ovf, fast_mul;
  logic [31:0] mag_a, mag_b, spec_res;
  logic [63:0] fprod;
  logic [32:0] mul_sum, rem_sh;
  logic [31:0] rem_sub;
  logic [63:0] prod_d, prod_neg, prod_sel;
  logic [31:0] quo, rem, result_d;

  // Operand signedness per funct3.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (bus.funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      3'b010:                         begin sgn_a = 1'b1; sgn_b = 1'b0; end
      default:                        begin sgn_a = 1'b0; sgn_b = 1'b0; end
    endcase
  end

  assign neg_a = sgn_a & bus.op_a_i[31];
  assign neg_b = sgn_b & bus.op_b_i[31];
  assign mag_a = neg_a ? (~bus.op_a_i + 32'd1) : bus.op_a_i;
  assign mag_b = neg_b ? (~bus.op_b_i + 32'd1) : bus.op_b_i;
  assign div0  = bus.funct3_i[2] & (bus.op_b_i == 32'd0);
  assign ovf   = bus.funct3_i[2] & ~bus.funct3_i[0] &
                 (bus.op_a_i == 32'h8000_0000) & (bus.op_b_i == 32'hFFFF_FFFF);

  // Results for the divide corner cases that skip the iteration.
  always_comb begin
    if (div0) begin
      spec_res = bus.funct3_i[1] ? bus.op_a_i : 32'hFFFF_FFFF;
    end else if (ovf) begin
      spec_res = bus.funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      spec_res = 32'd0;
    end
  end

`ifdef RV32M_FAST_MUL_EN
  logic [63:0] fa, fb;
  assign fa       = {{32{neg_a}}, bus.op_a_i};
  assign fb       = {{32{neg_b}}, bus.op_b_i};
  assign fprod    = fa * fb;
  assign fast_mul = ~bus.funct3_i[2];
`else
  assign fprod    = 64'd0;
  assign fast_mul = 1'b0;
`endif

  // One iteration: prod_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, b_q} : 33'd0);
    rem_sh  = {prod_q[63:32], prod_q[31]};
    rem_sub = rem_sh[31:0] - b_q;
    if (fn_q[2]) begin
      if (rem_sh >= {1'b0, b_q}) begin
        prod_d = {rem_sub, prod_q[30:0], 1'b1};
      end else begin
        prod_d = {prod_q[62:0], 1'b0};
      end
    end else begin
      prod_d = {mul_sum, prod_q[31:1]};
    end
  end

  // Sign fix-up and result selection; bypassed results are already final.
  always_comb begin
    prod_neg = ~prod_q + 64'd1;
    prod_sel = neg_q ? prod_neg : prod_q;
    quo      = neg_q ? (~prod_q[31:0] + 32'd1) : prod_q[31:0];
    rem      = neg_rem_q ? (~prod_q[63:32] + 32'd1) : prod_q[63:32];
    if (bypass_q) begin
      result_d = ((fn_q == 3'b000) || fn_q[2]) ? prod_q[31:0] : prod_q[63:32];
    end else begin
      case (fn_q)
        3'b000:                 result_d = prod_sel[31:0];
        3'b001, 3'b010, 3'b011: result_d = prod_sel[63:32];
        3'b100, 3'b101:         result_d = quo;
        default:                result_d = rem;
      endcase
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      fn_q      <= 3'd0;
      rd_q      <= 5'd0;
      b_q       <= 32'd0;
      prod_q    <= 64'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bypass_q  <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            fn_q      <= bus.funct3_i;
            rd_q      <= bus.rd_addr_i;
            b_q       <= mag_b;
            neg_q     <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b1;
            if (div0 | ovf) begin
              prod_q   <= {32'd0, spec_res};
              bypass_q <= 1'b1;
              state_q  <= FIX;
            end else if (fast_mul) begin
              prod_q   <= fprod;
              bypass_q <= 1'b1;
              state_q  <= FIX;
            end else begin
              prod_q   <= {32'd0, mag_a};
              bypass_q <= 1'b0;
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= result_d;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.rd_addr_o = rd_q;
endmodule

// File: doc/rv32m_muldiv.md
Name: rv32m_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read operands plus the destination register index.
- Produces a 32-bit result with the rd index for the writeback path, which drives the register-file write port.
- Multi-cycle with start/busy and valid/ready handshakes; the pipeline stalls while busy_o is high.

Parameters:
XLEN, 32, operand/result width; only 32 is supported, and the counter width is derived as $clog2(XLEN)+1

Ports:
clk_i  input  1  clock; all state updates on posedge
reset_i  input  1  synchronous, active-low reset
start_i  input  1  request; accepted only in IDLE
funct3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a_i  input  32  rs1 value (register-file read port 1)
op_b_i  input  32  rs2 value (register-file read port 2)
rd_addr_i  input  5  destination register index
ready_i  input  1  writeback accepts result
busy_o  output  1  high in any state except IDLE
valid_o  output  1  result_o/rd_addr_o valid
result_o  output  32  result
rd_addr_o  output  5  latched rd index

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset: reset_i low at a posedge forces IDLE, valid_o=0, busy_o=0, result_o=0, rd_addr_o=0, and clears all internal registers. Reset aborts any operation in flight with no result.
- Accept, edge N (IDLE && start_i):
  - Latch funct3, rd_addr, operand magnitudes and sign flags; clear the counter.
  - Signed ops: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats a as signed, b as unsigned. Unsigned ops use raw values.
  - Next state is CALC, unless a special case applies, in which case go directly to FIX.
- start_i outside IDLE is ignored and no request is queued.
- CALC: one iteration per cycle, 32 cycles (edges N+1..N+32), then FIX.
  - Multiply: shift-add over |a|*|b| into a 64-bit product.
  - Divide: restoring, 1 quotient bit per cycle; |a|/|b| gives the quotient and remainder magnitudes.
- FIX (edge N+33) registers result_o and selects the output:
  - MUL returns product[31:0]; the MULH* ops return product[63:32].
  - Product is negated (64-bit two's complement) if the operand signs differ for the op's signedness.
  - Quotient is negated if the signs differ (signed DIV).
  - Remainder takes the sign of the dividend (signed REM).
  - Transition to DONE.
- DONE: valid_o=1, result_o/rd_addr_o held stable.
  - Edge with ready_i=1 returns to IDLE and clears valid_o.
  - ready_i low holds indefinitely.
- Latency, start accept to valid_o: 34 cycles normal, 2 cycles special case. There is a minimum 1 idle cycle between results.
- Special cases, detected at accept (bypass CALC):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000; REM gives 0.
- rd_addr_i==0 is still computed and presented; the register file discards the write.
- Operands are sampled only at accept; later input changes are ignored.

Optional Feature:
RV32M_FAST_MUL_EN:
- Defined: MUL/MULH/MULHSU/MULHU skip CALC. A single-cycle 64-bit signed/unsigned multiply is performed at accept and the result is registered in FIX, giving valid_o 2 cycles after accept. Divides are unchanged at 34 cycles.
- Undefined: all multiplies use the iterative 34-cycle path.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3), rd=5, ready_i=1 -> valid_o 34 cycles after accept, result_o=0xFFFFFFEB, rd_addr_o=5, valid_o high exactly 1 cycle.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF with valid 2 cycles after accept. REM a=5, b=0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Backpressure: ready_i low for 5 cycles in DONE -> result_o/valid_o held. Extra start_i pulses during busy are ignored. After ready_i, the next start is accepted only once busy_o=0.
- reset_i low at cycle 10 of CALC -> next cycle busy_o=0, valid_o=0, result_o=0. A new DIVU 9/3 afterwards -> 3.
